// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX stop-bit checking path.
// Holds the per-frame FSM state encoding and the stop-bit configuration codes.
package uart_rx_pkg;

    // Per-frame stop-bit checker states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STOP1 = 2'd1,
        STOP2 = 2'd2
    } stop_state_e;

    // Stop-bit configuration codes as latched at frame start
    localparam logic STOP_CFG_ONE = 1'b0;
    localparam logic STOP_CFG_TWO = 1'b1;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_stop_frame_check_sat_counter.sv
// sat_counter: saturating event counter with synchronous clear.
// A clear coincident with an increment leaves the count at 1 so that the
// event arriving in the clear cycle is not lost. Reused for the parity and
// framing error counters elsewhere in the RX path.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Increment that sticks at the all-ones value instead of wrapping
    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + W'(1);
    endfunction

    // Count register: clear has priority, but a same-cycle event still counts once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule : sat_counter

// File: rtl/uart_rx_stop_frame_check.sv
// uart_rx_stop_frame_check: checks 1 or 2 stop bits per UART frame.
// frame_start arms the checker and latches the stop-bit count; each
// stp_chk_en strobe samples one stop bit. Stop_Error and frame_done are
// registered and appear one cycle after the final stop-bit strobe.
// A sticky error flag collects errors until err_clr.
// Optional build macro STOP_ERR_CNT_EN adds a saturating errored-frame
// counter on err_count; without it err_count is tied to zero.
module uart_rx_stop_frame_check
    import uart_rx_pkg::*;
#(
    parameter int NUM_STOP_MAX = 2,
    parameter int CNT_W        = 8
) (
    input  logic             CLK_stop,
    input  logic             RST_stop,
    input  logic             frame_start,
    input  logic             stop_cfg,
    input  logic             stp_chk_en,
    input  logic             sample_bit,
    input  logic             err_clr,
    output logic             Stop_Error,
    output logic             frame_done,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    // Two stop bits can only be selected when the build supports them
    localparam logic TWO_STOP_OK = (NUM_STOP_MAX == 2);

    stop_state_e state_q;
    stop_state_e state_n;
    logic        cfg_q;
    logic        cfg_n;
    logic        err1_q;
    logic        err1_n;
    logic        stop_err_n;
    logic        done_n;
    logic        err_set;
    logic        sticky_n;

    // Next-state and per-frame result logic; frame_start overrides everything
    always_comb begin
        state_n    = state_q;
        cfg_n      = cfg_q;
        err1_n     = err1_q;
        stop_err_n = Stop_Error;
        done_n     = 1'b0;

        if (frame_start) begin
            // New frame or resync: discard any frame in flight
            state_n    = STOP1;
            cfg_n      = (stop_cfg == STOP_CFG_TWO && TWO_STOP_OK) ? STOP_CFG_TWO
                                                                   : STOP_CFG_ONE;
            err1_n     = 1'b0;
            stop_err_n = 1'b0;
        end else begin
            case (state_q)
                STOP1: begin
                    if (stp_chk_en) begin
                        if (cfg_q == STOP_CFG_ONE) begin
                            stop_err_n = ~sample_bit;
                            done_n     = 1'b1;
                            state_n    = IDLE;
                        end else begin
                            err1_n  = ~sample_bit;
                            state_n = STOP2;
                        end
                    end
                end
                STOP2: begin
                    if (stp_chk_en) begin
                        stop_err_n = err1_q | ~sample_bit;
                        done_n     = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: begin
                    // IDLE ignores strobes; the unused encoding recovers to IDLE
                    state_n = IDLE;
                end
            endcase
        end

        err_set  = done_n & stop_err_n;
        sticky_n = err_set | (err_sticky & ~err_clr);
    end

    // FSM, latched configuration and registered outputs
    always_ff @(posedge CLK_stop or negedge RST_stop) begin
        if (!RST_stop) begin
            state_q    <= IDLE;
            cfg_q      <= STOP_CFG_ONE;
            err1_q     <= 1'b0;
            Stop_Error <= 1'b0;
            frame_done <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state_q    <= state_n;
            cfg_q      <= cfg_n;
            err1_q     <= err1_n;
            Stop_Error <= stop_err_n;
            frame_done <= done_n;
            err_sticky <= sticky_n;
        end
    end

`ifdef STOP_ERR_CNT_EN
    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (CLK_stop),
        .rst_n (RST_stop),
        .inc   (err_set),
        .clr   (err_clr),
        .count (err_count)
    );
`else
    assign err_count = '0;
`endif

endmodule : uart_rx_stop_frame_check

// File: tb/tb_uart_rx_stop_frame_check.sv
// Testbench for uart_rx_stop_frame_check (CNT_W = 2 to reach saturation quickly).
// Expected counter values apply only when STOP_ERR_CNT_EN is defined;
// otherwise err_count must stay zero.
module tb_uart_rx_stop_frame_check;

    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef STOP_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             CLK_stop;
    logic             RST_stop;
    logic             frame_start;
    logic             stop_cfg;
    logic             stp_chk_en;
    logic             sample_bit;
    logic             err_clr;
    logic             Stop_Error;
    logic             frame_done;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;

    uart_rx_stop_frame_check #(
        .NUM_STOP_MAX (2),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK_stop    (CLK_stop),
        .RST_stop    (RST_stop),
        .frame_start (frame_start),
        .stop_cfg    (stop_cfg),
        .stp_chk_en  (stp_chk_en),
        .sample_bit  (sample_bit),
        .err_clr     (err_clr),
        .Stop_Error  (Stop_Error),
        .frame_done  (frame_done),
        .err_sticky  (err_sticky),
        .err_count   (err_count)
    );

    initial CLK_stop = 1'b0;
    always #5 CLK_stop = ~CLK_stop;

    typedef struct {
        bit cfg;
        bit s1;
        bit s2;
        bit clr;
        bit exp_err;
        bit exp_sticky;
        int exp_cnt;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: sticky = any error since last clear, count = errors since clear (saturating)
    bit ref_sticky = 1'b0;
    int ref_cnt    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge CLK_stop);
        #1;
    endtask

    function automatic int cnt_out(input int c);
        return CNT_ON ? c : 0;
    endfunction

    task automatic model_done(input bit e, input bit c);
        if (c) begin
            ref_sticky = e;
            ref_cnt    = e ? 1 : 0;
        end else if (e) begin
            ref_sticky = 1'b1;
            if (ref_cnt < CNT_MAX) ref_cnt++;
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            sample_bit = 1'($urandom);
            tick();
        end
    endtask

    // One complete frame; err_clr is pulsed together with the final strobe when clr=1
    task automatic run_frame(input string tag, input bit cfg, input bit s1, input bit s2,
                             input bit clr, input bit exp_err, input bit exp_sticky,
                             input int exp_cnt, input int gap);
        frame_start = 1'b1;
        stop_cfg    = cfg;
        tick();
        frame_start = 1'b0;
        stop_cfg    = 1'($urandom);
        check({tag, "_start_err"}, int'(Stop_Error), 0);
        idle_gap(gap);
        if (cfg) begin
            stp_chk_en = 1'b1;
            sample_bit = s1;
            tick();
            stp_chk_en = 1'b0;
            check({tag, "_mid_done"}, int'(frame_done), 0);
            idle_gap(gap);
        end
        stp_chk_en = 1'b1;
        sample_bit = cfg ? s2 : s1;
        err_clr    = clr;
        tick();
        stp_chk_en = 1'b0;
        err_clr    = 1'b0;
        check({tag, "_done"}, int'(frame_done), 1);
        check({tag, "_err"}, int'(Stop_Error), int'(exp_err));
        check({tag, "_sticky"}, int'(err_sticky), int'(exp_sticky));
        check({tag, "_cnt"}, int'(err_count), cnt_out(exp_cnt));
        tick();
        check({tag, "_done_pulse"}, int'(frame_done), 0);
        check({tag, "_err_hold"}, int'(Stop_Error), int'(exp_err));
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{cfg:0, s1:1, s2:0, clr:0, exp_err:0, exp_sticky:0, exp_cnt:0};
        vecs[1] = '{cfg:0, s1:0, s2:1, clr:0, exp_err:1, exp_sticky:1, exp_cnt:1};
        vecs[2] = '{cfg:0, s1:1, s2:0, clr:0, exp_err:0, exp_sticky:1, exp_cnt:1};
        vecs[3] = '{cfg:1, s1:1, s2:0, clr:0, exp_err:1, exp_sticky:1, exp_cnt:2};
        vecs[4] = '{cfg:1, s1:0, s2:1, clr:0, exp_err:1, exp_sticky:1, exp_cnt:3};
        vecs[5] = '{cfg:1, s1:1, s2:1, clr:0, exp_err:0, exp_sticky:1, exp_cnt:3};
        vecs[6] = '{cfg:0, s1:0, s2:0, clr:0, exp_err:1, exp_sticky:1, exp_cnt:3};
        vecs[7] = '{cfg:1, s1:0, s2:0, clr:0, exp_err:1, exp_sticky:1, exp_cnt:3};
        vecs[8] = '{cfg:0, s1:0, s2:1, clr:1, exp_err:1, exp_sticky:1, exp_cnt:1};
        vecs[9] = '{cfg:1, s1:1, s2:1, clr:1, exp_err:0, exp_sticky:0, exp_cnt:0};

        RST_stop    = 1'b0;
        frame_start = 1'b0;
        stop_cfg    = 1'b0;
        stp_chk_en  = 1'b0;
        sample_bit  = 1'b1;
        err_clr     = 1'b0;
        repeat (3) tick();
        check("rst_err", int'(Stop_Error), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_sticky", int'(err_sticky), 0);
        check("rst_cnt", int'(err_count), 0);
        RST_stop = 1'b1;
        tick();

        // Directed table of frames
        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].s1, vecs[i].s2,
                      vecs[i].clr, vecs[i].exp_err, vecs[i].exp_sticky,
                      vecs[i].exp_cnt, i % 3);
            model_done(vecs[i].exp_err, vecs[i].clr);
        end

        // Abort: two-stop frame restarted after first strobe with one-stop config
        frame_start = 1'b1; stop_cfg = 1'b1; tick(); frame_start = 1'b0;
        stp_chk_en = 1'b1; sample_bit = 1'b0; tick(); stp_chk_en = 1'b0;
        frame_start = 1'b1; stop_cfg = 1'b0; tick(); frame_start = 1'b0;
        check("abort_no_done", int'(frame_done), 0);
        check("abort_err_clr", int'(Stop_Error), 0);
        check("abort_cnt", int'(err_count), cnt_out(ref_cnt));
        tick();
        check("abort_no_done2", int'(frame_done), 0);
        stp_chk_en = 1'b1; sample_bit = 1'b1; tick(); stp_chk_en = 1'b0;
        check("abort_new_cfg_done", int'(frame_done), 1);
        check("abort_new_err", int'(Stop_Error), 0);
        model_done(1'b0, 1'b0);

        // frame_start and stp_chk_en together: the strobe is ignored
        frame_start = 1'b1; stop_cfg = 1'b0; stp_chk_en = 1'b1; sample_bit = 1'b0; tick();
        frame_start = 1'b0; stp_chk_en = 1'b0;
        check("coinc_no_done", int'(frame_done), 0);
        check("coinc_err", int'(Stop_Error), 0);
        stp_chk_en = 1'b1; sample_bit = 1'b0; tick(); stp_chk_en = 1'b0;
        check("coinc_done", int'(frame_done), 1);
        check("coinc_err2", int'(Stop_Error), 1);
        model_done(1'b1, 1'b0);
        check("coinc_sticky", int'(err_sticky), int'(ref_sticky));

        // Standalone err_clr
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        model_done(1'b0, 1'b1);
        check("clr_sticky", int'(err_sticky), 0);
        check("clr_cnt", int'(err_count), 0);
        check("clr_err_hold", int'(Stop_Error), 1);

        // Randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            bit c, a, b, k, e;
            c = 1'($urandom);
            a = ($urandom_range(0, 3) != 0);
            b = ($urandom_range(0, 3) != 0);
            k = ($urandom_range(0, 7) == 0);
            e = c ? (!a || !b) : !a;
            model_done(e, k);
            run_frame($sformatf("rnd%0d", i), c, a, b, k, e, ref_sticky, ref_cnt,
                      $urandom_range(0, 3));
        end

        // Reset asserted while waiting for the second stop bit, after an error
        run_frame("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                  (ref_cnt < CNT_MAX) ? ref_cnt + 1 : ref_cnt, 0);
        frame_start = 1'b1; stop_cfg = 1'b1; tick(); frame_start = 1'b0;
        stp_chk_en = 1'b1; sample_bit = 1'b0; tick(); stp_chk_en = 1'b0;
        RST_stop = 1'b0;
        #1;
        check("arst_err", int'(Stop_Error), 0);
        check("arst_done", int'(frame_done), 0);
        check("arst_sticky", int'(err_sticky), 0);
        check("arst_cnt", int'(err_count), 0);
        #2;
        RST_stop = 1'b1;
        ref_sticky = 1'b0;
        ref_cnt    = 0;
        tick();

        // Strobes without frame_start must be ignored
        stp_chk_en = 1'b1; sample_bit = 1'b0; tick();
        sample_bit = 1'b0; tick(); stp_chk_en = 1'b0;
        check("idle_strobe_done", int'(frame_done), 0);
        tick();
        check("idle_strobe_done2", int'(frame_done), 0);
        check("idle_strobe_err", int'(Stop_Error), 0);
        check("idle_strobe_sticky", int'(err_sticky), 0);
        check("idle_strobe_cnt", int'(err_count), 0);

        // A fresh frame after reset works normally
        run_frame("post_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_rx_stop_frame_check
